// File: rtl/alsu_sched_pkg.sv
// alsu_sched_pkg: shared types and constants for the ALSU round-robin scheduler.
package alsu_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  localparam logic [2:0] OP_AND   = 3'd0;
  localparam logic [2:0] OP_XOR   = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_MUL   = 3'd3;
  localparam logic [2:0] OP_SHIFT = 3'd4;
  localparam logic [2:0] OP_ROT   = 3'd5;

  // Input register plus output register inside the ALSU.
  localparam int unsigned ALSU_LAT_DEFAULT = 2;

  // Park values: bypass A with A=0 so the ALSU output settles to 0.
  localparam logic [2:0] PARK_A        = 3'd0;
  localparam logic [2:0] PARK_B        = 3'd0;
  localparam logic [2:0] PARK_OPCODE   = 3'd0;
  localparam logic       PARK_BYPASS_A = 1'b1;
  localparam logic       PARK_CTRL     = 1'b0;

  // Opcodes above OP_ROT have no defined ALSU function.
  function automatic logic is_illegal_op(input logic [2:0] op);
    return op > OP_ROT;
  endfunction

endpackage

// File: rtl/alsu_sched_rr_arbiter.sv
// alsu_sched_rr_arbiter: combinational round-robin pick, searching upward from ptr+1.
module alsu_sched_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_valid
);

  // First requester after the pointer wins; wraps from NUM_REQ-1 back to 0.
  always_comb begin
    int unsigned idx;
    logic [ID_W-1:0] sel;
    gnt       = '0;
    gnt_id    = '0;
    gnt_valid = 1'b0;
    idx       = 0;
    sel       = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      sel = ID_W'(idx);
      if (en && !gnt_valid && req[sel]) begin
        gnt_valid = 1'b1;
        gnt[sel]  = 1'b1;
        gnt_id    = sel;
      end
    end
  end

endmodule

// File: rtl/alsu_sched.sv
// alsu_sched: round-robin scheduler sharing one ALSU between NUM_REQ requesters.
// Optional: define ALSU_OPCHECK_EN to reject opcodes 6/7 without touching the ALSU.
module alsu_sched
  import alsu_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ID_W     = 2,
  parameter int unsigned ALSU_LAT = ALSU_LAT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [3*NUM_REQ-1:0] req_opcode,
  input  logic [3*NUM_REQ-1:0] req_a,
  input  logic [3*NUM_REQ-1:0] req_b,
  input  logic [NUM_REQ-1:0]   req_cin,
  input  logic [NUM_REQ-1:0]   req_si,
  input  logic [NUM_REQ-1:0]   req_dir,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [2:0]           alsu_a,
  output logic [2:0]           alsu_b,
  output logic [2:0]           alsu_opcode,
  output logic                 alsu_cin,
  output logic                 alsu_si,
  output logic                 alsu_direction,
  output logic                 alsu_bypass_a,
  output logic                 alsu_bypass_b,
  output logic                 alsu_red_op_a,
  output logic                 alsu_red_op_b,
  input  logic [5:0]           alsu_out,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic [5:0]           rsp_data,
  output logic                 rsp_err,
  output logic                 busy
);

  localparam int unsigned CntW = (ALSU_LAT > 1) ? $clog2(ALSU_LAT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(ALSU_LAT - 1);

  state_e          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [2:0]      op_q, op_d, a_q, a_d, b_q, b_d;
  logic            cin_q, cin_d, si_q, si_d, dir_q, dir_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [5:0]      rsp_data_q, rsp_data_d;

  logic               arb_en, arb_valid;
  logic [ID_W-1:0]    arb_id;
  logic [2:0]         op_arr [NUM_REQ];
  logic [2:0]         a_arr  [NUM_REQ];
  logic [2:0]         b_arr  [NUM_REQ];

  alsu_sched_rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_arb (
    .req      (req),
    .ptr      (ptr_q),
    .en       (arb_en),
    .gnt      (gnt),
    .gnt_id   (arb_id),
    .gnt_valid(arb_valid)
  );

  // Unpack the per-requester operand slices.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      op_arr[k] = req_opcode[3*k +: 3];
      a_arr[k]  = req_a[3*k +: 3];
      b_arr[k]  = req_b[3*k +: 3];
    end
  end

  // Next-state: arbitration in IDLE/RESP, issue, latency wait, response capture.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    cin_d       = cin_q;
    si_d        = si_q;
    dir_d       = dir_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    arb_en      = 1'b0;
    unique case (state_q)
      StIdle, StResp: begin
        arb_en  = 1'b1;
        state_d = StIdle;
        if (arb_valid) begin
          ptr_d   = arb_id;
          op_d    = op_arr[arb_id];
          a_d     = a_arr[arb_id];
          b_d     = b_arr[arb_id];
          cin_d   = req_cin[arb_id];
          si_d    = req_si[arb_id];
          dir_d   = req_dir[arb_id];
          state_d = StIssue;
`ifdef ALSU_OPCHECK_EN
          // Rejected ops answer straight away and leave the ALSU parked.
          if (is_illegal_op(op_arr[arb_id])) begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_id_d    = arb_id;
            rsp_data_d  = '0;
          end
`endif
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        // Wait spans ALSU_LAT cycles so the capture edge follows the ALSU output register.
        if (cnt_q == CntLast) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = ptr_q;  // pointer still holds the owner of the op in flight
          rsp_data_d  = alsu_out;
          state_d     = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and holding registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= ID_W'(NUM_REQ - 1);
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      si_q        <= 1'b0;
      dir_q       <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cin_q       <= cin_d;
      si_q        <= si_d;
      dir_q       <= dir_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // ALSU drive: latched fields while active, park values otherwise.
  always_comb begin
    alsu_a         = PARK_A;
    alsu_b         = PARK_B;
    alsu_opcode    = PARK_OPCODE;
    alsu_cin       = PARK_CTRL;
    alsu_si        = PARK_CTRL;
    alsu_direction = PARK_CTRL;
    alsu_bypass_a  = PARK_BYPASS_A;
    alsu_bypass_b  = PARK_CTRL;
    alsu_red_op_a  = PARK_CTRL;
    alsu_red_op_b  = PARK_CTRL;
    if (state_q == StIssue || state_q == StWait) begin
      alsu_a         = a_q;
      alsu_b         = b_q;
      alsu_opcode    = op_q;
      alsu_cin       = cin_q;
      alsu_si        = si_q;
      alsu_direction = dir_q;
      alsu_bypass_a  = 1'b0;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_alsu_sched.sv
// tb_alsu_sched: scoreboard bench for alsu_sched with a two-register ALSU model.
module tb_alsu_sched;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int LAT     = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req;
  logic [3*NUM_REQ-1:0] req_opcode, req_a, req_b;
  logic [NUM_REQ-1:0]   req_cin, req_si, req_dir;
  logic [NUM_REQ-1:0]   gnt;
  logic [2:0]           alsu_a, alsu_b, alsu_opcode;
  logic                 alsu_cin, alsu_si, alsu_direction;
  logic                 alsu_bypass_a, alsu_bypass_b, alsu_red_op_a, alsu_red_op_b;
  logic [5:0]           alsu_out;
  logic                 rsp_valid;
  logic [ID_W-1:0]      rsp_id;
  logic [5:0]           rsp_data;
  logic                 rsp_err;
  logic                 busy;

  alsu_sched #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W),
    .ALSU_LAT(LAT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .req_opcode    (req_opcode),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_cin       (req_cin),
    .req_si        (req_si),
    .req_dir       (req_dir),
    .gnt           (gnt),
    .alsu_a        (alsu_a),
    .alsu_b        (alsu_b),
    .alsu_opcode   (alsu_opcode),
    .alsu_cin      (alsu_cin),
    .alsu_si       (alsu_si),
    .alsu_direction(alsu_direction),
    .alsu_bypass_a (alsu_bypass_a),
    .alsu_bypass_b (alsu_bypass_b),
    .alsu_red_op_a (alsu_red_op_a),
    .alsu_red_op_b (alsu_red_op_b),
    .alsu_out      (alsu_out),
    .rsp_valid     (rsp_valid),
    .rsp_id        (rsp_id),
    .rsp_data      (rsp_data),
    .rsp_err       (rsp_err),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // ---------------- ALSU model: input register, then output register ----------------
  logic [2:0] m_a, m_b, m_op;
  logic       m_cin, m_si, m_dir, m_ba, m_bb, m_ra, m_rb;
  logic [5:0] m_out;

  function automatic logic [5:0] alsu_f(input logic [2:0] op, input logic [2:0] a,
                                        input logic [2:0] b, input logic cin, input logic si,
                                        input logic dir, input logic ba, input logic bb,
                                        input logic ra, input logic rb, input logic [5:0] cur);
    if (ba) return {3'b0, a};
    if (bb) return {3'b0, b};
    case (op)
      3'd0: return ra ? {5'b0, &a} : (rb ? {5'b0, &b} : {3'b0, a & b});
      3'd1: return ra ? {5'b0, ^a} : (rb ? {5'b0, ^b} : {3'b0, a ^ b});
      3'd2: return 6'(a) + 6'(b) + 6'(cin);
      3'd3: return 6'(a) * 6'(b);
      3'd4: return dir ? {cur[4:0], si} : {si, cur[5:1]};
      3'd5: return dir ? {cur[4:0], cur[5]} : {cur[0], cur[5:1]};
      default: return 6'd0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {m_a, m_b, m_op} <= '0;
      {m_cin, m_si, m_dir, m_bb, m_ra, m_rb} <= '0;
      m_ba  <= 1'b1;
      m_out <= '0;
    end else begin
      m_a   <= alsu_a;
      m_b   <= alsu_b;
      m_op  <= alsu_opcode;
      m_cin <= alsu_cin;
      m_si  <= alsu_si;
      m_dir <= alsu_direction;
      m_ba  <= alsu_bypass_a;
      m_bb  <= alsu_bypass_b;
      m_ra  <= alsu_red_op_a;
      m_rb  <= alsu_red_op_b;
      m_out <= alsu_f(m_op, m_a, m_b, m_cin, m_si, m_dir, m_ba, m_bb, m_ra, m_rb, m_out);
    end
  end
  assign alsu_out = m_out;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [ID_W-1:0] id;
    logic [5:0]      data;
    logic            err;
    int              due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Every response is matched against the oldest expectation, including its cycle.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp: got id=%0d data=%0d err=%0d cyc=%0d, required none",
                 rsp_id, rsp_data, rsp_err, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (rsp_id !== mon_e.id || rsp_data !== mon_e.data || rsp_err !== mon_e.err ||
            cyc != mon_e.due) begin
          errors++;
          $display("FAIL rsp: got id=%0d data=%0d err=%0d cyc=%0d, required id=%0d data=%0d err=%0d cyc=%0d",
                   rsp_id, rsp_data, rsp_err, cyc, mon_e.id, mon_e.data, mon_e.err, mon_e.due);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int id, input logic [5:0] d, input logic err, input int due);
    exp_t e;
    e.id   = ID_W'(id);
    e.data = d;
    e.err  = err;
    e.due  = due;
    sb.push_back(e);
  endtask

  task automatic set_fields(input int i, input logic [2:0] op, input logic [2:0] a,
                            input logic [2:0] b, input logic cin, input logic si,
                            input logic dir);
    req_opcode[3*i +: 3] = op;
    req_a[3*i +: 3]      = a;
    req_b[3*i +: 3]      = b;
    req_cin[i]           = cin;
    req_si[i]            = si;
    req_dir[i]           = dir;
  endtask

  task automatic wait_gnt(input int budget);
    int n = 0;
    @(negedge clk);
    while (gnt == '0 && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
  endtask

  task automatic apply_reset();
    req   = '0;
    rst_n = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n      = 1'b0;
    req        = '0;
    req_opcode = '0;
    req_a      = '0;
    req_b      = '0;
    req_cin    = '0;
    req_si     = '0;
    req_dir    = '0;
    #3;
    checks++;
    if ({gnt, rsp_valid, busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctl: got gnt=%b rsp_valid=%b busy=%b, required 0 0 0",
               gnt, rsp_valid, busy);
    end
    checks++;
    if ({rsp_id, rsp_data, rsp_err} !== 9'b0) begin
      errors++;
      $display("FAIL reset_rsp: got id=%0d data=%0d err=%b, required 0 0 0",
               rsp_id, rsp_data, rsp_err);
    end
    checks++;
    if ({alsu_bypass_a, alsu_a, alsu_b, alsu_opcode, alsu_cin, alsu_si, alsu_direction,
         alsu_bypass_b, alsu_red_op_a, alsu_red_op_b} !== 16'h8000) begin
      errors++;
      $display("FAIL reset_park: got byp_a=%b a=%0d b=%0d op=%0d ctl=%b%b%b%b%b%b, required 1 0 0 0 000000",
               alsu_bypass_a, alsu_a, alsu_b, alsu_opcode, alsu_cin, alsu_si, alsu_direction,
               alsu_bypass_b, alsu_red_op_a, alsu_red_op_b);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single_add();
    int t;
    step();
    set_fields(0, 3'd2, 3'd3, 3'd5, 1'b1, 1'b0, 1'b0);
    req = 4'b0001;
    wait_gnt(10);
    t = cyc;
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL add_gnt: got %b, required 0001", gnt);
    end
    push_exp(0, 6'd9, 1'b0, t + 4);
    step();
    req = '0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || alsu_opcode !== 3'd2 || alsu_a !== 3'd3 || alsu_b !== 3'd5 ||
        alsu_cin !== 1'b1 || alsu_bypass_a !== 1'b0) begin
      errors++;
      $display("FAIL add_issue: got busy=%b op=%0d a=%0d b=%0d cin=%b byp=%b, required 1 2 3 5 1 0",
               busy, alsu_opcode, alsu_a, alsu_b, alsu_cin, alsu_bypass_a);
    end
    drain(20);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL add_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_back_to_back();
    int t;
    int prev = 0;
    logic [3:0] exp_g;
    apply_reset();
    for (int i = 0; i < NUM_REQ; i++) set_fields(i, 3'd3, 3'd2, 3'd3, 1'b0, 1'b0, 1'b0);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(10);
      t     = cyc;
      exp_g = 4'(1 << (k % 4));
      checks++;
      if (gnt !== exp_g) begin
        errors++;
        $display("FAIL b2b_gnt%0d: got %b, required %b", k, gnt, exp_g);
      end
      if (k > 0) begin
        checks++;
        if (t - prev != LAT + 2) begin
          errors++;
          $display("FAIL b2b_gap%0d: got %0d cycles, required %0d", k, t - prev, LAT + 2);
        end
      end
      push_exp(k % 4, 6'd6, 1'b0, t + 4);
      prev = t;
    end
    step();
    req = '0;
    drain(40);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_shift_rot();
    logic [2:0] ops [2];
    logic [5:0] exp_d [2];
    int t;
    ops   = '{3'd4, 3'd5};
    exp_d = '{6'd1, 6'd0};
    for (int k = 0; k < 2; k++) begin
      step();
      set_fields(2, ops[k], 3'd0, 3'd0, 1'b0, 1'b1, 1'b1);
      req = 4'b0100;
      wait_gnt(10);
      t = cyc;
      checks++;
      if (gnt !== 4'b0100) begin
        errors++;
        $display("FAIL shrot_gnt%0d: got %b, required 0100", k, gnt);
      end
      push_exp(2, exp_d[k], 1'b0, t + 4);
      step();
      req = '0;
      drain(20);
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL shrot_drain%0d: got %0d pending, required 0", k, sb.size());
      end
    end
  endtask

  task automatic test_opcheck();
    int t;
    step();
    set_fields(1, 3'd7, 3'd5, 3'd3, 1'b0, 1'b0, 1'b0);
    req = 4'b0010;
    wait_gnt(10);
    t = cyc;
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL opchk_gnt: got %b, required 0010", gnt);
    end
`ifdef ALSU_OPCHECK_EN
    push_exp(1, 6'd0, 1'b1, t + 1);
`else
    push_exp(1, 6'd0, 1'b0, t + 4);
`endif
    step();
    req = '0;
    @(negedge clk);
    checks++;
`ifdef ALSU_OPCHECK_EN
    if (alsu_bypass_a !== 1'b1 || alsu_opcode !== 3'd0 || alsu_a !== 3'd0) begin
      errors++;
      $display("FAIL opchk_park: got byp=%b op=%0d a=%0d, required 1 0 0",
               alsu_bypass_a, alsu_opcode, alsu_a);
    end
`else
    if (alsu_bypass_a !== 1'b0 || alsu_opcode !== 3'd7 || alsu_a !== 3'd5) begin
      errors++;
      $display("FAIL opchk_issue: got byp=%b op=%0d a=%0d, required 0 7 5",
               alsu_bypass_a, alsu_opcode, alsu_a);
    end
`endif
    drain(20);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL opchk_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_reset_abort();
    int t;
    int t2;
    int seen = 0;
    step();
    set_fields(0, 3'd2, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0);
    req = 4'b0001;
    wait_gnt(10);
    step();
    req = '0;
    @(posedge clk);  // now in the wait phase
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || gnt !== '0 || alsu_bypass_a !== 1'b1) begin
      errors++;
      $display("FAIL abort_now: got busy=%b rsp_valid=%b gnt=%b byp=%b, required 0 0 0000 1",
               busy, rsp_valid, gnt, alsu_bypass_a);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_silent: got %0d responses, required 0", seen);
    end
    step();
    set_fields(0, 3'd0, 3'd7, 3'd7, 1'b0, 1'b0, 1'b0);
    set_fields(3, 3'd1, 3'd6, 3'd3, 1'b0, 1'b0, 1'b0);
    req = 4'b1001;
    wait_gnt(10);
    t = cyc;
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL abort_first: got %b, required 0001", gnt);
    end
    push_exp(0, 6'd7, 1'b0, t + 4);
    step();
    req = 4'b1000;
    wait_gnt(10);
    t2 = cyc;
    checks++;
    if (gnt !== 4'b1000 || t2 - t != LAT + 2) begin
      errors++;
      $display("FAIL abort_second: got gnt=%b gap=%0d, required 1000 gap=%0d", gnt, t2 - t, LAT + 2);
    end
    push_exp(3, 6'd5, 1'b0, t2 + 4);
    step();
    req = '0;
    drain(20);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL abort_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_latched();
    int t;
    step();
    set_fields(1, 3'd0, 3'd7, 3'd5, 1'b0, 1'b0, 1'b0);
    req = 4'b0010;
    wait_gnt(10);
    t = cyc;
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL latch_gnt: got %b, required 0010", gnt);
    end
    push_exp(1, 6'd5, 1'b0, t + 4);
    step();
    req = '0;
    set_fields(1, 3'd1, 3'd0, 3'd0, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if (alsu_opcode !== 3'd0 || alsu_a !== 3'd7 || alsu_b !== 3'd5) begin
      errors++;
      $display("FAIL latch_issue: got op=%0d a=%0d b=%0d, required 0 7 5",
               alsu_opcode, alsu_a, alsu_b);
    end
    drain(20);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL latch_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_back_to_back();
    test_shift_rot();
    test_opcheck();
    test_reset_abort();
    test_latched();
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
